iob_wishbone2iob: RTL and testbench

Wishbone classic slave to IOb master bridge, the reverse direction of the IOb-to-Wishbone bridge. It accepts single Wishbone cycles from a Wishbone master (e.g. the ethmac DMA port), replays each as one IOb transaction towards IOb memory/peripherals, and returns ack or error. Registered, single-outstanding, with an optional response timeout.

---
 rtl/iob_wishbone2iob.sv | 95 +++++++++
 tb/tb_iob_wishbone2iob.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb master bridge: one registered, single-outstanding
// transfer at a time, with an optional response timeout that reports a bus error.
module iob_wishbone2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                wb_ack_o,
  output logic                wb_error_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

  localparam logic                 TO_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK, ERR} state_t;

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 abort;
  logic                 we_r;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      address_o <= '0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      wb_data_o <= '0;
      we_r      <= 1'b0;
      cnt       <= '0;
      abort     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (wb_cyc_i && wb_stb_i) begin
          address_o <= wb_addr_i;
          wdata_o   <= wb_data_i;
          wstrb_o   <= wb_we_i ? wb_select_i : '0;
          we_r      <= wb_we_i;
          cnt       <= '0;
          abort     <= 1'b0;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // The master may walk away mid-cycle; the IOb side still has to finish.
          if (!wb_cyc_i) abort <= 1'b1;
          if (ready_i && !abort && !we_r) wb_data_o <= rdata_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    valid_o    = 1'b0;
    wb_ack_o   = 1'b0;
    wb_error_o = 1'b0;
    case (state)
      IDLE: if (wb_cyc_i && wb_stb_i) state_nxt = REQ;
      REQ: begin
        valid_o = 1'b1;
        // ready wins over an expiring timeout in the same cycle
        if (ready_i)                        state_nxt = abort ? IDLE : ACK;
        else if (TO_EN && (cnt == TO_LAST)) state_nxt = ERR;
      end
      ACK: begin
        wb_ack_o  = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        wb_error_o = !abort;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Directed bench for iob_wishbone2iob: reads, waited writes, timeout, abort,
// async reset mid-transfer and a back-to-back write/read sequence.
module tb_iob_wishbone2iob;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] wb_addr = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [31:0] wb_wdat = '0;
  logic [31:0] wb_rdat;
  logic        wb_ack, wb_err, valid;
  logic [31:0] address, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(8), .TIMEOUT(4)) dut (
    .clk_i(clk), .arst_i(arst),
    .wb_addr_i(wb_addr), .wb_select_i(wb_sel), .wb_we_i(wb_we),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_data_i(wb_wdat),
    .wb_data_o(wb_rdat), .wb_ack_o(wb_ack), .wb_error_o(wb_err),
    .valid_o(valid), .address_o(address), .wdata_o(wdata), .wstrb_o(wstrb),
    .rdata_i(rdata), .ready_i(ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One Wishbone cycle; the IOb side answers after `waits` extra cycles.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, input int waits, input logic [31:0] rd,
                      output logic [31:0] got);
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = addr; wb_wdat = data; wb_sel = sel;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk("req_valid", valid, 1);
      chk("req_addr", address, addr);
      chk("req_wstrb", wstrb, we ? sel : 4'h0);
      if (we) chk("req_wdata", wdata, data);
      chk("req_no_ack", wb_ack, 0);
      if (i == waits) begin ready = 1; rdata = rd; end
    end
    @(negedge clk);
    ready = 0;
    chk("ack_hi", wb_ack, 1);
    chk("ack_no_err", wb_err, 0);
    chk("ack_valid_lo", valid, 0);
    got = wb_rdat;
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
    chk("ack_one_cycle", wb_ack, 0);
  endtask

  logic [31:0] got;
  logic [31:0] mem [0:7];

  initial begin
    // reset state
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_ack", wb_ack, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_rdata", wb_rdat, 0);
    chk("rst_wstrb", wstrb, 0);
    @(negedge clk); @(negedge clk);
    arst = 0;

    // zero-wait read
    xfer(0, 32'h40, 32'h0, 4'hF, 0, 32'hDEADBEEF, got);
    chk("rd0_data", got, 32'hDEADBEEF);

    // write with 3 wait cycles leaves read data alone
    xfer(1, 32'h10, 32'h12345678, 4'b0011, 3, 32'hFFFF_FFFF, got);
    chk("wr3_rdata_kept", got, 32'hDEADBEEF);

    // timeout: valid for 4 cycles, then one error pulse
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_valid", valid, 1);
    end
    @(negedge clk);
    chk("to_err", wb_err, 1);
    chk("to_no_ack", wb_ack, 0);
    chk("to_valid_lo", valid, 0);
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
    chk("to_err_one", wb_err, 0);
    xfer(0, 32'h44, 32'h0, 4'hF, 1, 32'hCAFEF00D, got);
    chk("to_next_rd", got, 32'hCAFEF00D);

    // abort: cyc dropped in cycle 2, ready in cycle 5 (timeout fires first, error suppressed)
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = 32'h48;
    @(negedge clk);
    chk("ab_valid", valid, 1);
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk); @(negedge clk);
    @(negedge clk);
    ready = 1; rdata = 32'hBAD0BAD0;
    chk("ab_c5_ack", wb_ack, 0);
    chk("ab_c5_err", wb_err, 0);
    chk("ab_c5_valid", valid, 0);
    @(negedge clk);
    ready = 0;
    chk("ab_c6_ack", wb_ack, 0);
    chk("ab_c6_err", wb_err, 0);
    chk("ab_c6_valid", valid, 0);
    chk("ab_rdata_kept", wb_rdat, 32'hCAFEF00D);

    // abort ended by ready before the timeout
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = 32'h4C;
    @(negedge clk);
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
    ready = 1; rdata = 32'h5555AAAA;
    @(negedge clk);
    ready = 0;
    chk("ab2_ack", wb_ack, 0);
    chk("ab2_err", wb_err, 0);
    chk("ab2_valid", valid, 0);
    chk("ab2_rdata_kept", wb_rdat, 32'hCAFEF00D);
    @(negedge clk);
    chk("ab2_idle_ack", wb_ack, 0);

    // async reset in REQ
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = 32'h50; wb_wdat = 32'h1; wb_sel = 4'hF;
    @(negedge clk);
    chk("rr_valid", valid, 1);
    arst = 1;
    #1;
    chk("rr_valid_lo", valid, 0);
    chk("rr_ack_lo", wb_ack, 0);
    chk("rr_err_lo", wb_err, 0);
    chk("rr_wstrb_lo", wstrb, 0);
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
    arst = 0;
    xfer(0, 32'h54, 32'h0, 4'hF, 0, 32'h0BADC0DE, got);
    chk("rr_next_rd", got, 32'h0BADC0DE);

    // back-to-back alternating write/read against a small memory model
    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, d;
      a = 32'h100 + 32'(i * 4);
      d = 32'hA5000000 + 32'(i * 32'h01010101);
      xfer(1, a, d, 4'hF, (i * 3) % 4, 32'hFFFF_FFFF, got);
      mem[i] = d;
      xfer(0, a, 32'h0, 4'hF, (i + 1) % 3, mem[i], got);
      chk("b2b_rd", got, 32'hA5000000 + 32'(i * 32'h01010101));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
